// File: rtl/link_seq_pkg.sv
// rtl/link_seq_pkg.sv - shared state encoding and default parameters for the link bring-up sequencer
package link_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TX_RST = 3'd1,
        RX_RST = 3'd2,
        ACQ    = 3'd3,
        LINKED = 3'd4,
        FAIL   = 3'd5
    } state_t;

    localparam int DEF_RST_CYCLES   = 16;
    localparam int DEF_DATA_DIV     = 8;
    localparam int DEF_LOCK_HOLD    = 4;
    localparam int DEF_LOCK_TIMEOUT = 1024;
    localparam int DEF_MAX_RETRY    = 3;

endpackage

// File: rtl/data_strobe_gen.sv
// rtl/data_strobe_gen.sv - free-running data strobe divider, parked at zero while hold is high
module data_strobe_gen #(
    parameter int DATA_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic stb
);

    localparam int DW = (DATA_DIV > 2) ? $clog2(DATA_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(DATA_DIV - 1);

    logic [DW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            stb <= 1'b0;
        end else if (hold) begin
            cnt <= '0;
            stb <= 1'b0;
        end else begin
            stb <= (cnt == LAST);
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/link_bringup_seq.sv
// rtl/link_bringup_seq.sv - orders tx/rx reset release, supervises rx lock with timeout and retry
// LINK_SEQ_RETRY_EN enables the retry counter; without it timeout and loss of lock go straight to FAIL.
module link_bringup_seq
    import link_seq_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int DATA_DIV     = DEF_DATA_DIV,
    parameter int LOCK_HOLD    = DEF_LOCK_HOLD,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRY    = DEF_MAX_RETRY,
    parameter int RW           = $clog2(MAX_RETRY + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          rx_lock,
    output logic          tx_rst_o,
    output logic          rx_rst_o,
    output logic          data_stb_o,
    output logic          busy_o,
    output logic          linked_o,
    output logic          fail_o,
    output logic [RW-1:0] retry_cnt_o
);

    localparam int PW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT);
    localparam int HW = $clog2(LOCK_HOLD + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_DONE  = HW'(LOCK_HOLD);

    state_t state, state_nxt, retry_target;

    logic [PW-1:0] phase_cnt;
    logic [TW-1:0] acq_timer;
    logic [HW-1:0] hold_cnt;
    logic          phase_done, lock_done, timeout;
    logic          tx_rst_d, rx_rst_d, busy_d, linked_d, fail_d;

    assign phase_done = (phase_cnt == PHASE_LAST);
    assign lock_done  = (hold_cnt == HOLD_DONE);
    assign timeout    = (acq_timer == TIMER_LAST);

`ifdef LINK_SEQ_RETRY_EN
    logic [RW-1:0] retry_cnt;
    logic          retry_evt;

    assign retry_evt    = ((state == ACQ) && !lock_done && timeout) ||
                          ((state == LINKED) && !rx_lock);
    assign retry_target = (retry_cnt < RW'(MAX_RETRY)) ? TX_RST : FAIL;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retry_cnt <= '0;
        end else if (abort) begin
            retry_cnt <= '0;
        end else if (((state == IDLE) || (state == FAIL)) && start) begin
            retry_cnt <= '0;
        end else if (retry_evt && (retry_cnt < RW'(MAX_RETRY))) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end

    assign retry_cnt_o = retry_cnt;
`else
    assign retry_target = FAIL;
    assign retry_cnt_o  = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Lock is checked before timeout so a coincident lock wins.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = TX_RST;
                TX_RST:  if (phase_done) state_nxt = RX_RST;
                RX_RST:  if (phase_done) state_nxt = ACQ;
                ACQ: begin
                    if (lock_done)    state_nxt = LINKED;
                    else if (timeout) state_nxt = retry_target;
                end
                LINKED:  if (!rx_lock) state_nxt = retry_target;
                FAIL:    if (start) state_nxt = TX_RST;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        tx_rst_d = (state_nxt == IDLE) || (state_nxt == TX_RST) || (state_nxt == FAIL);
        rx_rst_d = (state_nxt != ACQ) && (state_nxt != LINKED);
        busy_d   = (state_nxt == TX_RST) || (state_nxt == RX_RST) || (state_nxt == ACQ);
        linked_d = (state_nxt == LINKED);
        fail_d   = (state_nxt == FAIL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_rst_o <= 1'b1;
            rx_rst_o <= 1'b1;
            busy_o   <= 1'b0;
            linked_o <= 1'b0;
            fail_o   <= 1'b0;
        end else begin
            tx_rst_o <= tx_rst_d;
            rx_rst_o <= rx_rst_d;
            busy_o   <= busy_d;
            linked_o <= linked_d;
            fail_o   <= fail_d;
        end
    end

    // Every counter restarts from zero whenever the state it belongs to is (re)entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_cnt <= '0;
            acq_timer <= '0;
            hold_cnt  <= '0;
        end else begin
            phase_cnt <= ((state_nxt == state) && ((state == TX_RST) || (state == RX_RST)))
                         ? phase_cnt + 1'b1 : '0;
            acq_timer <= ((state_nxt == ACQ) && (state == ACQ)) ? acq_timer + 1'b1 : '0;
            hold_cnt  <= ((state_nxt == ACQ) && (state == ACQ) && rx_lock)
                         ? hold_cnt + 1'b1 : '0;
        end
    end

    data_strobe_gen #(
        .DATA_DIV (DATA_DIV)
    ) u_data_strobe_gen (
        .clk  (clk),
        .rst  (rst),
        .hold (tx_rst_o),
        .stb  (data_stb_o)
    );

endmodule

// File: tb/tb_link_bringup_seq.sv
// tb/tb_link_bringup_seq.sv - directed bench for link_bringup_seq with default parameters
module tb_link_bringup_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       rx_lock = 1'b0;
    logic       tx_rst_o, rx_rst_o, data_stb_o, busy_o, linked_o, fail_o;
    logic [1:0] retry_cnt_o;
    logic       seen;

    int checks = 0;
    int errors = 0;

    link_bringup_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .rx_lock     (rx_lock),
        .tx_rst_o    (tx_rst_o),
        .rx_rst_o    (rx_rst_o),
        .data_stb_o  (data_stb_o),
        .busy_o      (busy_o),
        .linked_o    (linked_o),
        .fail_o      (fail_o),
        .retry_cnt_o (retry_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx"}, tx_rst_o, 1);
        check({tag, "_rx"}, rx_rst_o, 1);
        check({tag, "_stb"}, data_stb_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_linked"}, linked_o, 0);
        check({tag, "_fail"}, fail_o, 0);
        check({tag, "_retry"}, retry_cnt_o, 0);
    endtask

    initial begin
        #1 rst = 1'b0;
        #12;
        check_reset_vals("por");
        rst = 1'b1;
        tick(2);
        check("idle_tx", tx_rst_o, 1);

        // Bring-up with rx_lock held high
        rx_lock = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("start_busy", busy_o, 1);
        check("start_tx", tx_rst_o, 1);
        tick(15);
        check("tx_hold15", tx_rst_o, 1);
        tick(1);
        check("tx_fall16", tx_rst_o, 0);
        check("rx_hold16", rx_rst_o, 1);
        seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            seen = seen | data_stb_o;
        end
        check("stb_gap1", seen, 0);
        tick(1);
        check("stb_first", data_stb_o, 1);
        seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            seen = seen | data_stb_o;
        end
        check("stb_gap2", seen, 0);
        check("rx_hold31", rx_rst_o, 1);
        tick(1);
        check("stb_second", data_stb_o, 1);
        check("rx_fall32", rx_rst_o, 0);
        tick(4);
        check("acq_pre_link", linked_o, 0);
        tick(1);
        check("linked", linked_o, 1);
        check("linked_busy", busy_o, 0);

        // Single-cycle loss of lock
        rx_lock = 1'b0;
        tick(1);
        rx_lock = 1'b1;
        check("lol_linked", linked_o, 0);
        check("lol_tx", tx_rst_o, 1);
        check("lol_rx", rx_rst_o, 1);
`ifdef LINK_SEQ_RETRY_EN
        check("lol_retry", retry_cnt_o, 1);
        check("lol_busy", busy_o, 1);
`else
        check("lol_fail", fail_o, 1);
        check("lol_retry", retry_cnt_o, 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("restart_busy", busy_o, 1);
`endif
        tick(32);
        check("reseq_rx_fall", rx_rst_o, 0);
        tick(5);
        check("relinked", linked_o, 1);
`ifdef LINK_SEQ_RETRY_EN
        check("relinked_retry", retry_cnt_o, 1);
`endif

        // Abort clears retries; lock toggling 3-high/1-low never links
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_linked", linked_o, 0);
        check("abort_retry", retry_cnt_o, 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(32);
        check("tog_acq_rx", rx_rst_o, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rx_lock = (i % 4) != 3;
            tick(1);
            seen = seen | linked_o;
        end
        check("tog_no_link", seen, 0);
        rx_lock = 1'b1;
        tick(4);
        check("tog_pre_link", linked_o, 0);
        tick(1);
        check("tog_linked", linked_o, 1);

        // Abort coincident with the 4th lock sample
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(32);
        tick(3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("ab4_linked", linked_o, 0);
        check("ab4_busy", busy_o, 0);
        check("ab4_tx", tx_rst_o, 1);
        check("ab4_retry", retry_cnt_o, 0);
        tick(1);
        check("ab4_linked_later", linked_o, 0);

        // Lock never arrives: timeout and retry exhaustion
        rx_lock = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
`ifdef LINK_SEQ_RETRY_EN
        for (int att = 0; att < 4; att++) begin
            tick(1055);
            check("to_pre_busy", busy_o, 1);
            check("to_pre_rx", rx_rst_o, 0);
            tick(1);
            if (att < 3) begin
                check("to_retry_tx", tx_rst_o, 1);
                check("to_retry_cnt", retry_cnt_o, att + 1);
                check("to_retry_busy", busy_o, 1);
            end else begin
                check("to_fail", fail_o, 1);
                check("to_fail_cnt", retry_cnt_o, 3);
                check("to_fail_busy", busy_o, 0);
            end
        end
`else
        tick(1055);
        check("to_pre_busy", busy_o, 1);
        check("to_pre_fail", fail_o, 0);
        tick(1);
        check("to_fail", fail_o, 1);
        check("to_fail_cnt", retry_cnt_o, 0);
        check("to_fail_tx", tx_rst_o, 1);
`endif
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("rearm_fail", fail_o, 0);
        check("rearm_busy", busy_o, 1);
        check("rearm_retry", retry_cnt_o, 0);

        // Asynchronous reset in the middle of RX_RST
        tick(19);
        check("mid_rx_tx", tx_rst_o, 0);
        check("mid_rx_rx", rx_rst_o, 1);
        #3 rst = 1'b0;
        #1;
        check_reset_vals("async");
        #2 rst = 1'b1;
        tick(5);
        check("post_rst_tx", tx_rst_o, 1);
        check("post_rst_busy", busy_o, 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("post_rst_start", busy_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/link_bringup_seq.md
# link_bringup_seq

Bring-up sequencer for the transmitter/receiver link. It orders the reset release of both halves and generates the m-sequence data strobe. It then supervises receiver lock acquisition, with timeout, retry and loss-of-lock handling. It sits at system top, driving the transmitter/receiver reset and data-rate inputs in place of free-running stimulus.

## Interface
Parameters:
- RST_CYCLES, 16: cycles each reset phase is held (≥1)
- DATA_DIV, 8: clk cycles per data strobe (≥2)
- LOCK_HOLD, 4: consecutive rx_lock cycles required to declare lock (≥1)
- LOCK_TIMEOUT, 1024: acquisition window in cycles (>LOCK_HOLD)
- MAX_RETRY, 3: retries before FAIL (≥1)
- RW, $clog2(MAX_RETRY+1): retry counter width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin/re-arm sequence; sampled only in IDLE or FAIL
- abort  in  1  return to IDLE; highest priority
- rx_lock  in  1  receiver lock indication, synchronous to clk
- tx_rst_o  out  1  transmitter reset, asserted high
- rx_rst_o  out  1  receiver reset, asserted high
- data_stb_o  out  1  one-cycle m-sequence data strobe
- busy_o  out  1  high in TX_RST, RX_RST, ACQ
- linked_o  out  1  high in LINKED
- fail_o  out  1  high in FAIL
- retry_cnt_o  out  RW  retries consumed in current attempt

## Operation
- States:
  - IDLE: both resets high. start → TX_RST.
  - TX_RST: both resets high for RST_CYCLES cycles, then → RX_RST.
  - RX_RST: tx released, rx held for RST_CYCLES cycles, then → ACQ.
  - ACQ: both resets low. Acquisition timer and hold counter run.
  - LINKED: link declared.
  - FAIL: both resets high. start → TX_RST with retry_cnt cleared.
- ACQ exits:
  - Hold counter reaches LOCK_HOLD → LINKED.
  - Timer reaches LOCK_TIMEOUT → retry.
  - rx_lock low clears the hold counter.
  - If lock and timeout fall on the same cycle, lock wins.
- LINKED: rx_lock low for one cycle = loss of lock → retry.
- Retry: if retry_cnt < MAX_RETRY, increment and → TX_RST; else → FAIL (retry_cnt holds MAX_RETRY).
- abort in any state → IDLE next edge, retry_cnt cleared. abort beats start, lock and timeout.
- start outside IDLE/FAIL is ignored.
- Data strobe divider:
  - Counter held at 0 while tx_rst_o=1.
  - Otherwise counts 0..DATA_DIV-1 and wraps.
  - data_stb_o=1 for the one cycle where the counter equals DATA_DIV-1.

## Timing
- Reset values: state IDLE, tx_rst_o=1, rx_rst_o=1, data_stb_o=0, busy_o=0, linked_o=0, fail_o=0, retry_cnt_o=0. All counters cleared.
- All outputs registered.
- start high at edge k → state TX_RST after edge k.
- tx_rst_o falls at edge k+RST_CYCLES. rx_rst_o falls at edge k+2·RST_CYCLES.
- First data_stb_o is DATA_DIV cycles after tx_rst_o falls.
- linked_o rises one edge after the LOCK_HOLD-th consecutive rx_lock sample.
- Loss of lock in LINKED: linked_o falls and both resets rise on the same edge.
- Timeout: fires when the ACQ timer equals LOCK_TIMEOUT-1. Transition occurs at edge ACQ-entry+LOCK_TIMEOUT.
- Reset asserted mid-operation forces reset values immediately, without waiting for clk.

## Configuration
- LINK_SEQ_RETRY_EN defined: retry behaviour as above.
- Undefined:
  - Timeout and loss of lock go directly to FAIL.
  - retry_cnt_o is tied to 0.
  - The retry counter is removed.

## Structure
- Package link_seq_pkg holds:
  - state enum (IDLE, TX_RST, RX_RST, ACQ, LINKED, FAIL)
  - default parameter constants
- Sub-module data_strobe_gen (DATA_DIV parameter; inputs clk, rst, hold; output stb) implements the divider.

## Test plan
- Defaults, start pulse, rx_lock tied high:
  - tx_rst_o falls after 16 cycles; rx_rst_o falls after 32.
  - First strobe 8 cycles after tx release, then every 8.
  - linked_o rises 4 cycles after ACQ entry plus one edge.
- rx_lock tied low, macro defined: 3 retries of 32+1024 cycles each, then fail_o=1 with retry_cnt_o=3. Without macro: fail_o after the first 1024-cycle window.
- rx_lock toggling 3-high/1-low in ACQ: no LINKED until the first window with 4 consecutive highs.
- rx_lock dropped 1 cycle in LINKED: linked_o=0, both resets high, retry_cnt_o=1, re-sequence.
- abort asserted in ACQ at the same cycle as the 4th lock sample: IDLE, linked_o stays 0, retry_cnt_o=0.
- rst pulsed low mid-RX_RST, asynchronous to clk: all outputs at reset values before the next clk edge. start is needed to restart.
